// File: rtl/mul_issue_queue.sv
// rtl/mul_issue_queue.sv - operand FIFO and single-flight issue controller for the Booth multiplier
// Optional WAIT watchdog enabled by defining MUL_ISSUE_TIMEOUT_EN.
module mul_issue_queue #(
    parameter int N       = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     In_Vld,
    output logic                     In_Rdy,
    input  logic [N-1:0]             In_M,
    input  logic [N-1:0]             In_R,
    output logic                     Mul_Ld,
    output logic [N-1:0]             Mul_M,
    output logic [N-1:0]             Mul_R,
    input  logic                     Mul_Valid,
    input  logic [2*N-1:0]           Mul_P,
    output logic                     Out_Vld,
    input  logic                     Out_Rdy,
    output logic [2*N-1:0]           Out_P,
    output logic                     Out_Err,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
        $error("mul_issue_queue: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [2*N-1:0]     mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q, count_d;
    logic [N-1:0]       mul_m_q, mul_m_d;
    logic [N-1:0]       mul_r_q, mul_r_d;
    logic               mv_q;
    logic               out_vld_q, out_vld_d;
    logic [2*N-1:0]     out_p_q, out_p_d;
    logic [2*N-1:0]     head;
    logic               full, push, pop, mv_edge;

    assign full    = (count_q == FULL_CNT);
    assign push    = In_Vld && !full;
    assign pop     = (state_q == S_ISSUE);
    assign mv_edge = Mul_Valid && !mv_q;
    assign head    = mem_q[rd_ptr_q];

`ifdef MUL_ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmr_q;
    logic          timeout_hit;
    logic          out_err_q, out_err_d;

    assign timeout_hit = (tmr_q == TW'(TIMEOUT - 1));

    // Counts cycles spent in WAIT; any other state holds it at zero.
    always_ff @(posedge Clk) begin
        if (Rst || state_q != S_WAIT) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_q + TW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            out_err_q <= 1'b0;
        end else begin
            out_err_q <= out_err_d;
        end
    end

    assign Out_Err = out_err_q;
`else
    assign Out_Err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        mul_m_d   = mul_m_q;
        mul_r_d   = mul_r_q;
        out_vld_d = out_vld_q;
        out_p_d   = out_p_q;
`ifdef MUL_ISSUE_TIMEOUT_EN
        out_err_d = out_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_ISSUE;
                    mul_m_d = head[2*N-1:N];
                    mul_r_d = head[N-1:0];
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mv_edge) begin
                    out_p_d   = Mul_P;
                    out_vld_d = 1'b1;
                    state_d   = S_HOLD;
`ifdef MUL_ISSUE_TIMEOUT_EN
                    out_err_d = 1'b0;
                end else if (timeout_hit) begin
                    out_p_d   = '0;
                    out_vld_d = 1'b1;
                    out_err_d = 1'b1;
                    state_d   = S_HOLD;
`endif
                end
            end
            S_HOLD: begin
                // Back-to-back issue straight from HOLD saves an IDLE cycle.
                if (Out_Rdy) begin
                    out_vld_d = 1'b0;
                    if (count_q != '0) begin
                        state_d = S_ISSUE;
                        mul_m_d = head[2*N-1:N];
                        mul_r_d = head[N-1:0];
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {In_M, In_R};
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            mul_m_q   <= '0;
            mul_r_q   <= '0;
            mv_q      <= 1'b0;
            out_vld_q <= 1'b0;
            out_p_q   <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            mul_m_q   <= mul_m_d;
            mul_r_q   <= mul_r_d;
            mv_q      <= Mul_Valid;
            out_vld_q <= out_vld_d;
            out_p_q   <= out_p_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    assign In_Rdy  = !full;
    assign Mul_Ld  = (state_q == S_ISSUE);
    assign Mul_M   = mul_m_q;
    assign Mul_R   = mul_r_q;
    assign Out_Vld = out_vld_q;
    assign Out_P   = out_p_q;
    assign Count   = count_q;

endmodule

// File: tb/tb_mul_issue_queue.sv
// tb/tb_mul_issue_queue.sv - self-checking bench for mul_issue_queue
// Timeout checks depend on MUL_ISSUE_TIMEOUT_EN.
module tb_mul_issue_queue;
    localparam int N       = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int LAT     = 4;

    logic                   Clk = 1'b0;
    logic                   Rst = 1'b1;
    logic                   In_Vld = 1'b0;
    logic                   In_Rdy;
    logic [N-1:0]           In_M = '0;
    logic [N-1:0]           In_R = '0;
    logic                   Mul_Ld;
    logic [N-1:0]           Mul_M;
    logic [N-1:0]           Mul_R;
    logic                   Mul_Valid = 1'b0;
    logic [2*N-1:0]         Mul_P = '0;
    logic                   Out_Vld;
    logic                   Out_Rdy = 1'b0;
    logic [2*N-1:0]         Out_P;
    logic                   Out_Err;
    logic [$clog2(DEPTH):0] Count;

    mul_issue_queue #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Rst(Rst), .In_Vld(In_Vld), .In_Rdy(In_Rdy), .In_M(In_M), .In_R(In_R),
        .Mul_Ld(Mul_Ld), .Mul_M(Mul_M), .Mul_R(Mul_R), .Mul_Valid(Mul_Valid), .Mul_P(Mul_P),
        .Out_Vld(Out_Vld), .Out_Rdy(Out_Rdy), .Out_P(Out_P), .Out_Err(Out_Err), .Count(Count)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;
    int retired = 0;
    bit mute = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    // Multiplier stand-in: Valid drops on load and rises LAT cycles later with the product.
    int lat_cnt = 0;
    logic signed [15:0] mprod;
    always @(negedge Clk) begin
        if (Mul_Ld) begin
            mprod     = $signed(Mul_M) * $signed(Mul_R);
            lat_cnt   = LAT;
            Mul_Valid = 1'b0;
            Mul_P     = 16'($urandom);
        end else if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0 && !mute) begin
                Mul_Valid = 1'b1;
                Mul_P     = mprod;
            end
        end
    end

    // Scoreboard: accepted operands in order, expected results per issue.
    typedef struct packed {logic [7:0] m; logic [7:0] r;} op_t;
    op_t            opq[$];
    logic [15:0]    resq[$];
    bit             errq[$];
    bit             prev_stall = 1'b0;
    logic [15:0]    prev_p = '0;
    bit             prev_ld = 1'b0;
    logic [7:0]     last_m = '0, last_r = '0;

    always @(negedge Clk) begin
        if (Rst) begin
            opq.delete();
            resq.delete();
            errq.delete();
            prev_stall = 1'b0;
            prev_ld    = 1'b0;
            last_m     = '0;
            last_r     = '0;
        end else begin
            chk("count", 32'(Count), 32'(opq.size()));
            chk("in_rdy", 32'(In_Rdy), 32'(opq.size() != DEPTH));
            if (prev_stall) begin
                chk("out_vld_hold", 32'(Out_Vld), 32'd1);
                chk("out_p_stable", 32'(Out_P), 32'(prev_p));
            end
            if (Mul_Ld) begin
                op_t op;
                int  pr;
                chk("ld_gap", 32'(prev_ld), 32'd0);
                chk("ld_vs_out_vld", 32'(Out_Vld), 32'd0);
                if (opq.size() == 0) begin
                    chk("ld_without_op", 32'd1, 32'd0);
                end else begin
                    op = opq.pop_front();
                    chk("mul_m", 32'(Mul_M), 32'(op.m));
                    chk("mul_r", 32'(Mul_R), 32'(op.r));
                    pr = $signed(op.m) * $signed(op.r);
                    resq.push_back(mute ? 16'h0 : pr[15:0]);
                    errq.push_back(mute);
                    last_m = op.m;
                    last_r = op.r;
                end
            end else begin
                chk("mul_m_stable", 32'(Mul_M), 32'(last_m));
                chk("mul_r_stable", 32'(Mul_R), 32'(last_r));
            end
            if (Out_Vld && Out_Rdy) begin
                if (resq.size() == 0) begin
                    chk("spurious_out", 32'd1, 32'd0);
                end else begin
                    chk("out_p", 32'(Out_P), 32'(resq.pop_front()));
                    chk("out_err", 32'(Out_Err), 32'(errq.pop_front()));
                end
                retired++;
            end
            prev_stall = Out_Vld && !Out_Rdy;
            prev_p     = Out_P;
            prev_ld    = Mul_Ld;
            if (In_Vld && In_Rdy) opq.push_back('{m: In_M, r: In_R});
        end
    end

    typedef struct {logic [7:0] m; logic [7:0] r; logic [15:0] p;} vec_t;
    vec_t vecs[7];

    task automatic wait_out(input string name);
        int n = 0;
        while (!Out_Vld && n < 60) begin
            tick();
            n++;
        end
        chk(name, 32'(Out_Vld), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int n;
        int target;
        bit rdy, v, seen;

        vecs[0] = '{m: 8'h07, r: 8'h06, p: 16'h002A};
        vecs[1] = '{m: 8'h80, r: 8'hFF, p: 16'h0080};
        vecs[2] = '{m: 8'h7F, r: 8'h80, p: 16'hC080};
        vecs[3] = '{m: 8'h80, r: 8'h80, p: 16'h4000};
        vecs[4] = '{m: 8'hFF, r: 8'hFF, p: 16'h0001};
        vecs[5] = '{m: 8'h7F, r: 8'h7F, p: 16'h3F01};
        vecs[6] = '{m: 8'h00, r: 8'h9C, p: 16'h0000};

        repeat (3) tick();
        chk("rst_in_rdy", 32'(In_Rdy), 32'd1);
        chk("rst_mul_ld", 32'(Mul_Ld), 32'd0);
        chk("rst_mul_m", 32'(Mul_M), 32'd0);
        chk("rst_mul_r", 32'(Mul_R), 32'd0);
        chk("rst_out_vld", 32'(Out_Vld), 32'd0);
        chk("rst_out_p", 32'(Out_P), 32'd0);
        chk("rst_out_err", 32'(Out_Err), 32'd0);
        chk("rst_count", 32'(Count), 32'd0);
        Rst = 1'b0;
        tick();

        // Single operations from the vector table, with issue timing.
        Out_Rdy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            In_M = vecs[i].m;
            In_R = vecs[i].r;
            In_Vld = 1'b1;
            tick();
            In_Vld = 1'b0;
            chk("vec_count1", 32'(Count), 32'd1);
            chk("vec_ld_early", 32'(Mul_Ld), 32'd0);
            tick();
            chk("vec_ld", 32'(Mul_Ld), 32'd1);
            tick();
            chk("vec_ld_once", 32'(Mul_Ld), 32'd0);
            wait_out("vec_out_wait");
            chk("vec_p", 32'(Out_P), 32'(vecs[i].p));
            chk("vec_err", 32'(Out_Err), 32'd0);
            tick();
            chk("vec_vld_1cyc", 32'(Out_Vld), 32'd0);
        end

        // Fill under backpressure: five accepts, then full.
        Out_Rdy = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            In_M = 8'(3 + 2 * i);
            In_R = 8'(4 + 2 * i);
            In_Vld = 1'b1;
            rdy = In_Rdy;
            tick();
            if (rdy) acc++;
            else break;
        end
        In_Vld = 1'b0;
        chk("fill_accepts", 32'(acc), 32'd5);
        repeat (10) tick();
        chk("fill_count", 32'(Count), 32'd4);
        chk("fill_in_rdy", 32'(In_Rdy), 32'd0);
        Out_Rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_out("fill_out_wait");
            chk("fill_p", 32'(Out_P), 32'((3 + 2 * k) * (4 + 2 * k)));
            tick();
        end

        // Random traffic with Out_Rdy toggling every 3 cycles.
        acc = 0;
        n = 0;
        target = retired + 20;
        while (retired < target && n < 3000) begin
            In_Vld  = (acc < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
            In_M    = 8'($urandom);
            In_R    = 8'($urandom);
            Out_Rdy = ((n / 3) % 2) == 0;
            rdy = In_Rdy;
            v = In_Vld;
            tick();
            if (v && rdy) acc++;
            n++;
        end
        In_Vld = 1'b0;
        chk("rand_drained", 32'(n < 3000), 32'd1);

        // Reset while WAIT with two queued.
        Out_Rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            In_M = 8'(i + 2);
            In_R = 8'(i + 9);
            In_Vld = 1'b1;
            tick();
        end
        In_Vld = 1'b0;
        chk("rstw_count2", 32'(Count), 32'd2);
        Rst = 1'b1;
        tick();
        chk("rstw_count", 32'(Count), 32'd0);
        chk("rstw_out_vld", 32'(Out_Vld), 32'd0);
        chk("rstw_mul_ld", 32'(Mul_Ld), 32'd0);
        Rst = 1'b0;
        seen = 1'b0;
        repeat (LAT + 8) begin
            tick();
            seen |= Out_Vld | Mul_Ld;
        end
        chk("rstw_quiet", 32'(seen), 32'd0);

        // Multiplier never answers.
        mute = 1'b1;
        Out_Rdy = 1'b0;
        In_M = 8'h11;
        In_R = 8'h22;
        In_Vld = 1'b1;
        tick();
        In_Vld = 1'b0;
        n = 0;
        while (!Mul_Ld && n < 10) begin
            tick();
            n++;
        end
        chk("to_ld_seen", 32'(Mul_Ld), 32'd1);
        seen = 1'b0;
        repeat (TIMEOUT) begin
            tick();
            seen |= Out_Vld;
        end
        chk("to_no_early_vld", 32'(seen), 32'd0);
`ifdef MUL_ISSUE_TIMEOUT_EN
        tick();
        chk("to_vld", 32'(Out_Vld), 32'd1);
        chk("to_err", 32'(Out_Err), 32'd1);
        chk("to_p", 32'(Out_P), 32'd0);
        Out_Rdy = 1'b1;
        tick();
        mute = 1'b0;
        In_M = 8'h07;
        In_R = 8'hFA;
        In_Vld = 1'b1;
        tick();
        In_Vld = 1'b0;
        wait_out("to_next_wait");
        chk("to_next_p", 32'(Out_P), 32'hFFD6);
        chk("to_err_clr", 32'(Out_Err), 32'd0);
        tick();
`else
        repeat (2 * TIMEOUT) begin
            tick();
            seen |= Out_Vld;
        end
        chk("to_stays_wait", 32'(seen), 32'd0);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        mute = 1'b0;
        tick();
`endif
        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
